// File: rtl/countdown_core.sv
// countdown_core: seconds countdown engine with prescaled decrement and expiry flag
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   load     - pulse, loads min(load_val, MAX_VAL) and returns to IDLE
//   load_val - initial seconds value
//   start    - pulse, starts or resumes counting
//   pause    - pulse, suspends counting
//   count    - remaining seconds (registered)
//   running  - high while in RUN
//   done     - high while in DONE
//   tick     - one-cycle pulse in the cycle count first shows a decremented value
module countdown_core #(
    parameter int BIN_WIDTH = 8,
    parameter int TICK_DIV  = 50_000_000,
    parameter int MAX_VAL   = 2**BIN_WIDTH-1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BIN_WIDTH-1:0] load_val,
    input  logic                 start,
    input  logic                 pause,
    output logic [BIN_WIDTH-1:0] count,
    output logic                 running,
    output logic                 done,
    output logic                 tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV-1);
    localparam logic [BIN_WIDTH-1:0] MAX_Q = BIN_WIDTH'(MAX_VAL);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_t;
    state_t state_q, state_d;
    logic [BIN_WIDTH-1:0] count_q, count_d;
    logic [PW-1:0] psc_q, psc_d;
    logic tick_q, tick_d;
    // start and pause together cancel each other
    logic go, hold, wrap;
    assign go   = start & ~pause;
    assign hold = pause & ~start;
    assign wrap = psc_q == PSC_LAST;
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        psc_d   = psc_q;
        tick_d  = 1'b0;
        if (load) begin
            count_d = load_val > MAX_Q ? MAX_Q : load_val;
            psc_d   = '0;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (go && count_q != '0) begin
                    state_d = RUN;
                    psc_d   = '0;
                end
                // pause still lets the prescaler advance on its own edge so the
                // cycles already spent in the period are kept for the resume
                RUN: begin
                    psc_d = wrap ? '0 : psc_q + PW'(1);
                    if (wrap) begin
                        count_d = count_q - BIN_WIDTH'(1);
                        tick_d  = 1'b1;
                    end
                    state_d = (wrap && count_q == BIN_WIDTH'(1)) ? DONE : hold ? PAUSED : RUN;
                end
                PAUSED: if (go) state_d = RUN;
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            psc_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            psc_q   <= psc_d;
            tick_q  <= tick_d;
        end
    end
    assign count   = count_q;
    assign running = state_q == RUN;
    assign done    = state_q == DONE;
    assign tick    = tick_q;
endmodule

// File: tb/tb_countdown_core.sv
// tb_countdown_core: directed self-checking bench for countdown_core
module tb_countdown_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load = 1'b0;
    logic [7:0] load_val = 8'd0;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic [7:0] count;
    logic running, done, tick;
    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;

    countdown_core #(.BIN_WIDTH(8), .TICK_DIV(4), .MAX_VAL(99)) dut (
        .clk(clk), .rst(rst), .load(load), .load_val(load_val),
        .start(start), .pause(pause), .count(count),
        .running(running), .done(done), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            tick_cnt += int'(tick);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v;
        load = 1'b1;
        steps(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        steps(1);
        start = 1'b0;
    endtask

    initial begin
        steps(2);
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_tick", tick, 0);
        do_start();
        check("rst_start_idle", running, 0);

        do_load(8'd3);
        check("basic_load", count, 3);
        do_start();
        check("basic_run", running, 1);
        tick_cnt = 0;
        steps(3);
        check("basic_e3_count", count, 3);
        check("basic_e3_tick", tick, 0);
        steps(1);
        check("basic_e4_count", count, 2);
        check("basic_e4_tick", tick, 1);
        steps(4);
        check("basic_e8_count", count, 1);
        steps(4);
        check("basic_e12_count", count, 0);
        check("basic_e12_done", done, 1);
        check("basic_e12_running", running, 0);
        check("basic_e12_tick", tick, 1);
        steps(20);
        check("basic_hold_done", done, 1);
        check("basic_hold_count", count, 0);
        check("basic_tick_total", tick_cnt, 3);
        do_start();
        check("done_ignores_start", done, 1);

        do_load(8'd5);
        check("pr_load_clears_done", done, 0);
        do_start();
        steps(5);
        check("pr_e5_count", count, 4);
        pause = 1'b1;
        steps(1);
        pause = 1'b0;
        check("pr_paused_running", running, 0);
        steps(10);
        check("pr_frozen_count", count, 4);
        check("pr_frozen_running", running, 0);
        do_start();
        check("pr_resume_running", running, 1);
        steps(1);
        check("pr_e1p1_count", count, 4);
        steps(1);
        check("pr_e1p2_count", count, 3);
        check("pr_e1p2_tick", tick, 1);
        steps(4);
        check("pr_e1p6_count", count, 2);

        do_load(8'd200);
        check("clamp_count", count, 99);
        do_start();
        steps(2);
        do_load(8'd7);
        check("reload_count", count, 7);
        check("reload_running", running, 0);
        check("reload_done", done, 0);
        do_start();
        steps(3);
        check("reload_e3_count", count, 7);
        steps(1);
        check("reload_e4_count", count, 6);

        do_load(8'd2);
        start = 1'b1;
        pause = 1'b1;
        steps(1);
        start = 1'b0;
        pause = 1'b0;
        check("sp_idle_running", running, 0);
        check("sp_idle_count", count, 2);
        load_val = 8'd9;
        load = 1'b1;
        start = 1'b1;
        steps(1);
        load = 1'b0;
        start = 1'b0;
        check("ls_count", count, 9);
        check("ls_running", running, 0);
        steps(1);
        check("ls_still_idle", running, 0);
        do_start();
        start = 1'b1;
        pause = 1'b1;
        steps(1);
        start = 1'b0;
        pause = 1'b0;
        check("sp_run_running", running, 1);

        do_load(8'd1);
        do_start();
        steps(3);
        pause = 1'b1;
        steps(1);
        pause = 1'b0;
        check("pwrap_done", done, 1);
        check("pwrap_running", running, 0);
        check("pwrap_count", count, 0);
        steps(2);
        check("pwrap_hold_done", done, 1);

        do_load(8'd0);
        tick_cnt = 0;
        do_start();
        check("zero_running", running, 0);
        check("zero_done", done, 0);
        steps(8);
        check("zero_tick_total", tick_cnt, 0);
        check("zero_count", count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
